sweep_step_scheduler: RTL
=========================

// Module: sweep_step_scheduler
// PURPOSE
//  Sequences a discrete frequency sweep for the DAC waveform generator and lock-in acquisition, in the ADC clock domain (50 MHz).
//  Per step: load frequency word, wait demodulator settle time, hold ADC acquire window, advance frequency.
//  Continuous mode holds one frequency and acquires until stopped.
//  Sits between clock_synchronizer (start/stop commands) and the DAC/data_processor paths.
// PARAMETERS
//  FREQ_W   32  integer width of frequency word (frequency_initial/final, freq_word)
//  FRAC_W   32  fractional bits of frequency_step; accumulator width = FREQ_W+FRAC_W
//  CNT_W    32  width of step_counter (acquire window length, cycles)
//  DLY_W    16  width of dem_delay (settle length, cycles)
// PORTS
//  clk_50             in   1               ADC-domain clock (ADC_outclock_50)
//  reset              in   1               synchronous, active-high
//  start_cmd          in   1               1-cycle pulse: begin sweep/continuous run
//  stop_cmd           in   1               1-cycle pulse: abort run
//  mode_nCont_disc    in   1               0 = continuous, 1 = discrete sweep
//  frequency_initial  in   FREQ_W          first frequency word
//  frequency_final    in   FREQ_W          last allowed frequency word (unsigned)
//  frequency_step     in   FREQ_W+FRAC_W   increment, int.frac
//  step_counter       in   CNT_W           acquire cycles per step
//  dem_delay          in   DLY_W           settle cycles before acquiring
//  freq_word          out  FREQ_W          current frequency (accumulator integer part)
//  freq_valid         out  1               1-cycle pulse when freq_word changes
//  ADC_acquire        out  1               high during acquire window
//  running            out  1               high in any state except IDLE/DONE
//  sweep_done         out  1               1-cycle pulse at natural sweep end
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; accumulator 0. Reset mid-run aborts with no sweep_done.
//  Parameters latched into shadow registers on accepted start_cmd; later input changes ignored until next start.
//  States: IDLE -> LOAD -> SETTLE -> ACQUIRE -> ADVANCE -> (LOAD | DONE) -> IDLE.
//  IDLE: start_cmd (and not stop_cmd) -> LOAD; acc <= {frequency_initial, FRAC_W'b0}.
//  LOAD (1 cycle): freq_word <= acc[int]; freq_valid=1; settle cnt <= dem_delay; dem_delay==0 -> ACQUIRE, else SETTLE.
//  SETTLE: decrement; on cnt==1 -> ACQUIRE. Settle lasts exactly dem_delay cycles.
//  ACQUIRE: ADC_acquire=1; window cnt <= max(step_counter,1); exactly that many cycles high.
//   Continuous mode: ADC_acquire stays high, no counting, leaves only via stop_cmd.
//  ADVANCE (1 cycle, ADC_acquire=0): nxt = acc + frequency_step (one extra carry bit).
//   carry-out, nxt[int] > frequency_final, or frequency_step==0 -> DONE; else acc<=nxt -> LOAD.
//  DONE (1 cycle): sweep_done=1, running=0 -> IDLE.
//  Timing: start_cmd at cycle k -> freq_valid at k+1; ADC_acquire first high at k+2+dem_delay.
//   Step-to-step period = 2 + dem_delay + max(step_counter,1) cycles.
//  stop_cmd in any non-IDLE state: next cycle IDLE, ADC_acquire/running low, no sweep_done, freq_word held.
//  start_cmd while running ignored. start_cmd & stop_cmd same cycle in IDLE: stop wins.
//  frequency_initial > frequency_final: one step at initial, then DONE.
//  freq_word is registered; never glitches; updates only in LOAD.
// STRUCTURE
//  Shared header sweep_defs.vh: state encodings (IDLE..DONE, 3-bit), width localparams.
//  Sub-module cycle_timer (load value, enable, done-at-1 flag), instantiated twice: settle and acquire counts.
//  Remainder: single FSM plus accumulator/comparator, all in clk_50.
// TESTING
//  disc, init=100, final=130, step=10.0, dem_delay=3, step_counter=5 -> freq_word 100,110,120,130;
//   4 freq_valid pulses 10 cycles apart; 4 acquire windows of 5; sweep_done 1 cycle after last ADVANCE.
//  dem_delay=0, step_counter=0 -> acquire 1 cycle; start->first acquire = 2 cycles; period 3.
//  step=0x0000_0000_8000_0000 (0.5), init=10, final=12 -> freq_word 10,10,11,11,12,12 -> 6 steps, done.
//  cont mode, init=500 -> freq_valid once, ADC_acquire high until stop_cmd; low next cycle, no sweep_done.
//  stop_cmd during SETTLE of step 2 -> IDLE next cycle, running=0; new start_cmd restarts from init.
//  reset asserted in ACQUIRE -> next cycle all outputs 0; start+stop same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/sweep_step_scheduler_pkg.sv
// Shared definitions for the frequency sweep step scheduler.
// Holds default widths and FSM state encodings.
package sweep_step_scheduler_pkg;

  localparam int FREQ_W_DEF = 32;
  localparam int FRAC_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;
  localparam int DLY_W_DEF  = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_ACQUIRE = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/sweep_step_scheduler_cycle_timer.sv
// Down-counter used for settle and acquire windows.
// Ports: clk, reset (sync, high), load/load_val, en (decrement), done (count==1).
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the last cycle of the window so the FSM leaves on time.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/sweep_step_scheduler.sv
// Sequences a discrete frequency sweep (or continuous hold) for DAC/ADC.
// Ports: clk_50, reset, start_cmd/stop_cmd, mode + sweep params in;
//   freq_word, freq_valid, ADC_acquire, running, sweep_done out.
module sweep_step_scheduler
  import sweep_step_scheduler_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DLY_W  = DLY_W_DEF
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     start_cmd,
  input  logic                     stop_cmd,
  input  logic                     mode_nCont_disc,
  input  logic [FREQ_W-1:0]        frequency_initial,
  input  logic [FREQ_W-1:0]        frequency_final,
  input  logic [FREQ_W+FRAC_W-1:0] frequency_step,
  input  logic [CNT_W-1:0]         step_counter,
  input  logic [DLY_W-1:0]         dem_delay,
  output logic [FREQ_W-1:0]        freq_word,
  output logic                     freq_valid,
  output logic                     ADC_acquire,
  output logic                     running,
  output logic                     sweep_done
);

  localparam int ACC_W = FREQ_W + FRAC_W;

  logic [2:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] final_q, final_d;
  logic [ACC_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              cont_q, cont_d;

  logic [ACC_W:0]    nxt;
  logic [FREQ_W-1:0] nxt_int;
  logic              sweep_end;
  logic [CNT_W-1:0]  win_len;
  logic              acq_load;
  logic              settle_done;
  logic              acq_done;

  // Extra top bit catches accumulator wrap past the integer range.
  assign nxt     = {1'b0, acc_q} + {1'b0, step_q};
  assign nxt_int = nxt[ACC_W-1:FRAC_W];
  assign sweep_end = nxt[ACC_W]
                   | (nxt_int > final_q)
                   | (step_q == '0);

  assign win_len = (win_q == '0) ? CNT_W'(1) : win_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    freq_d   = freq_q;
    final_d  = final_q;
    step_d   = step_q;
    win_d    = win_q;
    dly_d    = dly_q;
    cont_d   = cont_q;
    acq_load = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_cmd && !stop_cmd) begin
          final_d = frequency_final;
          step_d  = frequency_step;
          win_d   = step_counter;
          dly_d   = dem_delay;
          cont_d  = ~mode_nCont_disc;
          acc_d   = {frequency_initial, {FRAC_W{1'b0}}};
          // Registered word lands together with the LOAD-cycle pulse.
          freq_d  = frequency_initial;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (dly_q == '0) begin
          acq_load = 1'b1;
          state_d  = S_ACQUIRE;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          acq_load = 1'b1;
          state_d  = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        if (!cont_q && acq_done) begin
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (sweep_end) begin
          state_d = S_DONE;
        end else begin
          acc_d   = nxt[ACC_W-1:0];
          freq_d  = nxt_int;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any step progress and keeps the current word.
    if (stop_cmd && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      acc_d    = acc_q;
      freq_d   = freq_q;
      acq_load = 1'b0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      freq_q  <= '0;
      final_q <= '0;
      step_q  <= '0;
      win_q   <= '0;
      dly_q   <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      final_q <= final_d;
      step_q  <= step_d;
      win_q   <= win_d;
      dly_q   <= dly_d;
      cont_q  <= cont_d;
    end
  end

  cycle_timer #(.W(DLY_W)) u_settle (
    .clk      (clk_50),
    .reset    (reset),
    .load     (state_q == S_LOAD),
    .load_val (dly_q),
    .en       (state_q == S_SETTLE),
    .done     (settle_done)
  );

  cycle_timer #(.W(CNT_W)) u_acq (
    .clk      (clk_50),
    .reset    (reset),
    .load     (acq_load),
    .load_val (win_len),
    .en       (state_q == S_ACQUIRE),
    .done     (acq_done)
  );

  assign freq_word   = freq_q;
  assign freq_valid  = (state_q == S_LOAD);
  assign ADC_acquire = (state_q == S_ACQUIRE);
  assign running     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign sweep_done  = (state_q == S_DONE);

endmodule
